// File: rtl/gate_compare_seq_pkg.sv
// Shared types and constants for the gate comparison sequencer.
// Holds the FSM state encoding, the sweep length and the implementation bit positions.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Bit positions in the disagree mask: structural, dataflow, behavioral.
    localparam int IDX_S = 0;
    localparam int IDX_D = 1;
    localparam int IDX_B = 2;

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

endpackage

// File: rtl/gate_compare_seq_if.sv
// Bundle of stimulus, implementation outputs and sweep results between the sequencer and its user.
// master drives start/abort and the three implementation outputs; slave is the sequencer.
interface gate_compare_seq_if;

    logic       start;
    logic       abort;
    logic [2:0] ys;
    logic [2:0] yd;
    logic [2:0] yb;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] mismatch_count;
    logic [1:0] first_fail_vec;
    logic [2:0] first_fail_mask;

    modport master (
        output start, abort, ys, yd, yb,
        input  a, b, busy, done, pass, mismatch_count, first_fail_vec, first_fail_mask
    );

    modport slave (
        input  start, abort, ys, yd, yb,
        output a, b, busy, done, pass, mismatch_count, first_fail_vec, first_fail_mask
    );

endinterface

// File: rtl/gate_compare_seq_vote3.sv
// Combinational 2-of-3 voter: per-bit majority of three 3-bit words and which inputs disagree with it.
module gate_vote3
    import gate_seq_pkg::*;
(
    input  logic [2:0] ys,
    input  logic [2:0] yd,
    input  logic [2:0] yb,
    output logic [2:0] maj,
    output logic [2:0] disagree
);

    always_comb begin
        maj             = (ys & yd) | (ys & yb) | (yd & yb);
        disagree        = 3'b000;
        disagree[IDX_S] = |(ys ^ maj);
        disagree[IDX_D] = |(yd ^ maj);
        disagree[IDX_B] = |(yb ^ maj);
    end

endmodule

// File: rtl/gate_compare_seq.sv
// Sweeps the four (a,b) input vectors through three gate implementations and majority-votes their outputs.
// state  | meaning
// IDLE   | waiting for start; results and last vector held
// SETTLE | current vector held for SETTLE_CYCLES cycles
// CHECK  | one cycle: vote, record mismatch, advance or finish
// DONE   | one-cycle done pulse with pass valid
module gate_compare_seq
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    gate_compare_seq_if.slave  bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] k;
    logic [1:0] k_next;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] mismatch_q;
    logic [1:0] fail_vec_q;
    logic [2:0] fail_mask_q;

    logic [2:0] maj;
    logic [2:0] disagree;
    logic       flagged;
    logic [2:0] count_next;

    gate_vote3 u_vote (
        .ys       (bus.ys),
        .yd       (bus.yd),
        .yb       (bus.yb),
        .maj      (maj),
        .disagree (disagree)
    );

    always_comb begin
        flagged    = |disagree;
        count_next = mismatch_q + {2'b00, flagged};
        k_next     = k + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            settle_cnt  <= 4'd0;
            k           <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mismatch_q  <= 3'd0;
            fail_vec_q  <= 2'd0;
            fail_mask_q <= 3'd0;
        end else if (state != ST_IDLE && bus.abort) begin
            // Partial mismatch/fail results stay visible after a cancel.
            state  <= ST_IDLE;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state       <= ST_SETTLE;
                        settle_cnt  <= SETTLE_LOAD;
                        k           <= 2'd0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        mismatch_q  <= 3'd0;
                        fail_vec_q  <= 2'd0;
                        fail_mask_q <= 3'd0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (flagged) begin
                        mismatch_q <= count_next;
                        if (mismatch_q == 3'd0) begin
                            fail_vec_q  <= k;
                            fail_mask_q <= disagree;
                        end
                    end
                    if (k == LAST_VEC) begin
                        // a,b keep the last vector so the idle outputs show what was swept.
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= (count_next == 3'd0);
                    end else begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        k          <= k_next;
                        a_q        <= k_next[0];
                        b_q        <= k_next[1];
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a               = a_q;
    assign bus.b               = b_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.mismatch_count  = mismatch_q;
    assign bus.first_fail_vec  = fail_vec_q;
    assign bus.first_fail_mask = fail_mask_q;

endmodule

// File: doc/gate_compare_seq.md
GATE_COMPARE_SEQ -- requirements
Module: gate_compare_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles each input vector is held before outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to run one full comparison sweep.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 ys  input  3  outputs y1,y2,y3 of the structural implementation, bit0=y1.
REQ-007 yd  input  3  outputs y1,y2,y3 of the dataflow implementation, bit0=y1.
REQ-008 yb  input  3  outputs y1,y2,y3 of the behavioral implementation, bit0=y1.
REQ-009 a  output  1  shared stimulus input a to all three implementations.
REQ-010 b  output  1  shared stimulus input b to all three implementations.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-013 pass  output  1  sweep result, valid from done until the next accepted start.
REQ-014 mismatch_count  output  3  number of vectors, 0..4, with any disagreement.
REQ-015 first_fail_vec  output  2  index of the first failing vector.
REQ-016 first_fail_mask  output  3  implementations that disagreed on the first failing vector; bit0=s, bit1=d, bit2=b.

Function
REQ-017 FSM states: IDLE, SETTLE, CHECK, DONE.
REQ-018 Vector order is k=0..3 with a=k[0], b=k[1], giving (a,b) = 00, 10, 01, 11.
REQ-019 In IDLE, start=1 shall clear the result registers, set busy=1 and a,b to vector 0 on the next cycle, and enter SETTLE.
REQ-020 start shall be ignored outside IDLE.
REQ-021 SETTLE shall hold a,b for exactly SETTLE_CYCLES cycles, then enter CHECK.
REQ-022 CHECK shall last one cycle and compute a per-bit majority reference from ys/yd/yb.
REQ-023 An implementation is flagged when any of its 3 bits differs from the majority reference.
REQ-024 If any implementation is flagged: mismatch_count increments, and on the first such vector first_fail_vec=k and first_fail_mask=flags.
REQ-025 After CHECK with k<3: k increments, a,b update on the next cycle, and the FSM re-enters SETTLE.
REQ-026 After CHECK with k=3: enter DONE.
REQ-027 DONE lasts one cycle with done=1, busy=0 and pass=(mismatch_count==0), then returns to IDLE.
REQ-028 Latency: with start accepted at cycle 0, vector k is applied at cycle 1+k*(SETTLE_CYCLES+1) and done is high at cycle 4*(SETTLE_CYCLES+1)+1 (cycle 13 at the default).
REQ-029 abort=1 in any non-IDLE state shall return the FSM to IDLE next cycle with a=b=0, busy=0, pass=0, no done pulse, and mismatch/fail registers holding partial values.
REQ-030 abort has priority over all transitions; start and abort asserted together in IDLE shall leave the FSM in IDLE.
REQ-031 mismatch_count cannot exceed 4; no wrap-around is possible.
REQ-032 In IDLE, results hold, and a=b=0 unless a sweep has completed, in which case a,b hold vector 3.

Reset
REQ-033 rst=1 shall force IDLE, a=0, b=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_vec=0, first_fail_mask=0, k=0.
REQ-034 rst asserted mid-sweep shall take effect on the next edge and override start and abort.

Structure
REQ-035 Package gate_seq_pkg shall hold the state enum, the NUM_VECTORS=4 constant and the implementation-index constants.
REQ-036 One sub-module, gate_vote3, shall be purely combinational, taking the three 3-bit inputs and producing the majority word and the 3-bit disagree mask.

Verification
REQ-037 Three identical AND/OR/XOR models, start at cycle 0 -> done at cycle 13, pass=1, mismatch_count=0.
REQ-038 Model d has y2 inverted only when a=1,b=0 -> pass=0, mismatch_count=1, first_fail_vec=1, first_fail_mask=3'b010.
REQ-039 Model b is stuck at 3'b000 -> mismatch_count equals the number of vectors where the majority is nonzero, and first_fail_mask=3'b100.
REQ-040 abort at cycle 5 -> a=b=0 and busy=0 at cycle 6, and no done pulse; a subsequent start gives a normal done 13 cycles later.
REQ-041 start pulsed at cycle 3 during a sweep -> ignored and done timing unchanged; start+abort together in IDLE -> FSM remains in IDLE.
REQ-042 rst at cycle 7 mid-sweep -> all outputs at reset values at cycle 8; SETTLE_CYCLES=1 sweep -> done at cycle 9.
